// File: rtl/depthwise_conv2d_stream.sv
// Streaming depthwise KxK convolution: raster pixels in (all channels per beat), line-buffered
// windows with internal zero padding, two-stage MAC / shift-saturate pipeline. Define DWCONV_RELU6_EN for fused ReLU6.
module depthwise_conv2d_stream #(
  parameter int CHANNELS    = 4,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int PADDING     = 1,
  parameter int IN_HEIGHT   = 16,
  parameter int IN_WIDTH    = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int FRAC_BITS   = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights,
  input  logic                                                  s_valid,
  output logic                                                  s_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                        s_data,
  output logic                                                  m_valid,
  input  logic                                                  m_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0]                        m_data,
  output logic                                                  m_last
);
  localparam int K       = KERNEL_SIZE;
  localparam int S       = STRIDE;
  localparam int P       = PADDING;
  localparam int DW      = DATA_WIDTH;
  localparam int CW      = CHANNELS * DW;
  localparam int PH      = IN_HEIGHT + 2 * P;
  localparam int PW      = IN_WIDTH + 2 * P;
  localparam int OUT_H   = (PH - K) / S + 1;
  localparam int OUT_W   = (PW - K) / S + 1;
  localparam int PROD_W  = 2 * DW;
  localparam int ACC_W   = 2 * DW + $clog2(K * K);
  localparam int LB_ROWS = (K > 1) ? K - 1 : 1;
  localparam int YW      = $clog2(PH + 1);
  localparam int XW      = $clog2(PW + 1);
  localparam int HI_I    = 2 ** (DW - 1) - 1;
  localparam int LO_I    = -(2 ** (DW - 1));

  localparam logic [YW-1:0] Y_LAST = YW'(PH - 1);
  localparam logic [XW-1:0] X_LAST = XW'(PW - 1);
  localparam logic [YW-1:0] Y_IN0  = YW'(P);
  localparam logic [YW-1:0] Y_IN1  = YW'(P + IN_HEIGHT - 1);
  localparam logic [XW-1:0] X_IN0  = XW'(P);
  localparam logic [XW-1:0] X_IN1  = XW'(P + IN_WIDTH - 1);
  localparam logic [YW-1:0] Y_WIN0 = YW'(K - 1);
  localparam logic [XW-1:0] X_WIN0 = XW'(K - 1);
  localparam logic [YW-1:0] Y_LWIN = YW'(K - 1 + (OUT_H - 1) * S);
  localparam logic [XW-1:0] X_LWIN = XW'(K - 1 + (OUT_W - 1) * S);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(HI_I);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(LO_I);

  function automatic logic signed [PROD_W-1:0] mul(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
    return a * b;
  endfunction

  function automatic logic signed [DW-1:0] shift_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic signed [DW-1:0]    r;
    s = a >>> FRAC_BITS;
    if (s > SAT_HI)      r = SAT_HI[DW-1:0];
    else if (s < SAT_LO) r = SAT_LO[DW-1:0];
    else                 r = s[DW-1:0];
    return r;
  endfunction

`ifdef DWCONV_RELU6_EN
  localparam int R6_I = ((6 << FRAC_BITS) < HI_I) ? (6 << FRAC_BITS) : HI_I;
  localparam logic signed [DW-1:0] R6_HI = DW'(R6_I);

  function automatic logic signed [DW-1:0] relu6(input logic signed [DW-1:0] v);
    logic signed [DW-1:0] r;
    r = v;
    if (v[DW-1])       r = '0;
    else if (v > R6_HI) r = R6_HI;
    return r;
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  logic [YW-1:0]   ph, row_ofs;
  logic [XW-1:0]   pw, col_ofs;
  logic            en, interior, step, last_in, at_end, win_ok, win_last;
  logic [CW-1:0]   px;
  logic [CW-1:0]   win  [K][K];
  logic [CW-1:0]   nwin [K][K];
  logic [CW-1:0]   lb   [LB_ROWS][PW];
  logic signed [ACC_W-1:0] acc_nxt [CHANNELS];
  logic signed [ACC_W-1:0] acc_p1  [CHANNELS];
  logic            vld_p1, last_p1;
  logic [CW-1:0]   m_nxt;

  assign en       = !(m_valid && !m_ready);
  assign interior = (ph >= Y_IN0) && (ph <= Y_IN1) && (pw >= X_IN0) && (pw <= X_IN1);
  assign s_ready  = en && (state == RUN) && interior;
  assign step     = en && (((state == RUN) && (!interior || s_valid)) || (state == DRAIN));
  assign last_in  = (ph == Y_IN1) && (pw == X_IN1);
  assign at_end   = (ph == Y_LAST) && (pw == X_LAST);
  assign px       = interior ? s_data : '0;
  assign row_ofs  = ph - Y_WIN0;
  assign col_ofs  = pw - X_WIN0;
  assign win_ok   = (ph >= Y_WIN0) && (pw >= X_WIN0) &&
                    ((S == 1) || (!row_ofs[0] && !col_ofs[0]));
  assign win_last = (ph == Y_LWIN) && (pw == X_LWIN);

  // Scanner: walks padded coordinates; padding positions step without consuming input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ph    <= '0;
      pw    <= '0;
    end else begin
      case (state)
        IDLE:    if (s_valid) state <= RUN;
        RUN:     if (step && interior && last_in) state <= (P == 0) ? IDLE : DRAIN;
        DRAIN:   if (step && at_end) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (step) begin
        if (pw == X_LAST) begin
          pw <= '0;
          ph <= (ph == Y_LAST) ? '0 : ph + 1'b1;
        end else begin
          pw <= pw + 1'b1;
        end
      end
    end
  end

  // Window as it will look after this step: shift left, new column from line buffers + pixel
  always_comb begin
    for (int kh = 0; kh < K; kh++) begin
      for (int kw = 0; kw < K - 1; kw++) nwin[kh][kw] = win[kh][kw+1];
      nwin[kh][K-1] = px;
    end
    for (int kh = 0; kh < K - 1; kh++) nwin[kh][K-1] = lb[kh][pw];
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      acc_nxt[c] = '0;
      for (int kh = 0; kh < K; kh++)
        for (int kw = 0; kw < K; kw++)
          acc_nxt[c] = acc_nxt[c] + ACC_W'(mul(nwin[kh][kw][c*DW +: DW],
                                               weights[((c*K+kh)*K+kw)*DW +: DW]));
    end
  end

  always_comb begin
    m_nxt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
`ifdef DWCONV_RELU6_EN
      m_nxt[c*DW +: DW] = relu6(shift_sat(acc_p1[c]));
`else
      m_nxt[c*DW +: DW] = shift_sat(acc_p1[c]);
`endif
    end
  end

  // Stage p1: line buffers, window and accumulators (data, no reset)
  always_ff @(posedge clk) begin
    if (step) begin
      for (int kh = 0; kh < K; kh++)
        for (int kw = 0; kw < K; kw++) win[kh][kw] <= nwin[kh][kw];
      for (int r = 0; r < LB_ROWS - 1; r++) lb[r][pw] <= lb[r+1][pw];
      lb[LB_ROWS-1][pw] <= px;
    end
    if (en)
      for (int c = 0; c < CHANNELS; c++) acc_p1[c] <= acc_nxt[c];
  end

  // Stage p2: valids, end-of-frame marker and saturated output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (en) begin
      vld_p1  <= step && win_ok;
      last_p1 <= step && win_ok && win_last;
      m_valid <= vld_p1;
      m_last  <= last_p1;
      m_data  <= m_nxt;
    end
  end
endmodule

// File: tb/tb_depthwise_conv2d_stream.sv
// Directed bench for depthwise_conv2d_stream: 2 channels, 3x3, 4x4 input, padding 1, strides 1 and 2.
module tb_depthwise_conv2d_stream;
  localparam int C = 2, K = 3, DW = 8, FB = 4, H = 4, W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [C*K*K*DW-1:0]   weights;
  logic                  s_valid;
  logic [C*DW-1:0]       s_data;
  logic                  m_ready;
  logic                  use_s2;
  logic                  s_ready1, m_valid1, m_last1, s_ready2, m_valid2, m_last2;
  logic [C*DW-1:0]       m_data1, m_data2;
  logic                  s_ready, m_valid, m_last;
  logic [C*DW-1:0]       m_data;

  assign s_ready = use_s2 ? s_ready2 : s_ready1;
  assign m_valid = use_s2 ? m_valid2 : m_valid1;
  assign m_last  = use_s2 ? m_last2  : m_last1;
  assign m_data  = use_s2 ? m_data2  : m_data1;

  depthwise_conv2d_stream #(.CHANNELS(C), .KERNEL_SIZE(K), .STRIDE(1), .PADDING(1),
    .IN_HEIGHT(H), .IN_WIDTH(W), .DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .weights(weights), .s_valid(s_valid && !use_s2),
    .s_ready(s_ready1), .s_data(s_data), .m_valid(m_valid1), .m_ready(m_ready),
    .m_data(m_data1), .m_last(m_last1));

  depthwise_conv2d_stream #(.CHANNELS(C), .KERNEL_SIZE(K), .STRIDE(2), .PADDING(1),
    .IN_HEIGHT(H), .IN_WIDTH(W), .DATA_WIDTH(DW), .FRAC_BITS(FB)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .weights(weights), .s_valid(s_valid && use_s2),
    .s_ready(s_ready2), .s_data(s_data), .m_valid(m_valid2), .m_ready(m_ready),
    .m_data(m_data2), .m_last(m_last2));

  int checks = 0;
  int errors = 0;
  int in0 [16];
  int in1 [16];
  int exp0 [16];
  int exp1 [16];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int post(input int v);
    int r;
    r = (v > 127) ? 127 : ((v < -128) ? -128 : v);
`ifdef DWCONV_RELU6_EN
    if (r < 0) r = 0;
    if (r > 96) r = 96;
`endif
    return r;
  endfunction

  task automatic set_w(input int centre, input int other);
    for (int c = 0; c < C; c++)
      for (int kh = 0; kh < K; kh++)
        for (int kw = 0; kw < K; kw++)
          weights[((c*K+kh)*K+kw)*DW +: DW] = (kh == 1 && kw == 1) ? 8'(centre) : 8'(other);
  endtask

  task automatic send(input int n, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 3000) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) s_valid = 1'b0;
      else begin
        s_valid = 1'b1;
        s_data  = {in1[i][7:0], in0[i][7:0]};
      end
      #2;
      if (s_valid && s_ready) i++;
      guard++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("send_beats", i, n);
  endtask

  task automatic recv(input string tag, input int n, input bit rand_rdy);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [C*DW-1:0] held = '0;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      m_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      #2;
      if (stalled) begin
        check({tag, "_hold_data"}, m_data, held);
        check({tag, "_hold_valid"}, m_valid, 1);
      end
      stalled = m_valid && !m_ready;
      if (stalled) begin
        held = m_data;
        check({tag, "_stall_s_ready"}, s_ready, 0);
      end
      if (m_valid && m_ready) begin
        check({tag, "_ch0"}, $signed(m_data[7:0]), exp0[got]);
        check({tag, "_ch1"}, $signed(m_data[15:8]), exp1[got]);
        check({tag, "_last"}, m_last, (got == n - 1) ? 1 : 0);
        got++;
      end
      cyc++;
    end
    @(negedge clk);
    m_ready = 1'b1;
    check({tag, "_count"}, got, n);
  endtask

  task automatic quiet(input string tag);
    int extra = 0;
    repeat (30) begin
      @(negedge clk);
      #2;
      if (m_valid) extra++;
    end
    check({tag, "_no_extra"}, extra, 0);
  endtask

  function automatic int taps(input int i);
    int r, c, nr, nc;
    r  = i / 4;
    c  = i % 4;
    nr = (r == 0 || r == 3) ? 2 : 3;
    nc = (c == 0 || c == 3) ? 2 : 3;
    return nr * nc;
  endfunction

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; use_s2 = 1'b0; weights = '0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_s_ready", s_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // identity kernel, ramp input
    set_w(16, 0);
    for (int i = 0; i < 16; i++) begin
      in0[i] = i; in1[i] = -i; exp0[i] = post(i); exp1[i] = post(-i);
    end
    fork send(16, 1'b0); recv("ident", 16, 1'b0); join
    quiet("ident");

    // all-16 weights and inputs: 16 * (number of in-image taps)
    set_w(16, 16);
    for (int i = 0; i < 16; i++) begin
      in0[i] = 16; in1[i] = 16; exp0[i] = post(16 * taps(i)); exp1[i] = exp0[i];
    end
    fork send(16, 1'b0); recv("ones", 16, 1'b0); join

    // negative saturation: 127 * -128 = -16256 per tap, >>>4 = -1016
    set_w(-128, -128);
    for (int i = 0; i < 16; i++) begin
      in0[i] = 127; in1[i] = 127; exp0[i] = post(-1016 * taps(i)); exp1[i] = exp0[i];
    end
    fork send(16, 1'b0); recv("negsat", 16, 1'b0); join

    set_w(16, 0);
    for (int i = 0; i < 16; i++) begin
      exp0[i] = post(127); exp1[i] = post(127);
    end
    fork send(16, 1'b0); recv("max", 16, 1'b0); join

    // identity again under random backpressure and input gaps
    for (int i = 0; i < 16; i++) begin
      in0[i] = i; in1[i] = -i; exp0[i] = post(i); exp1[i] = post(-i);
    end
    fork send(16, 1'b1); recv("bp", 16, 1'b1); join
    quiet("bp");

    // stride 2: pixels (0,0),(0,2),(2,0),(2,2)
    use_s2 = 1'b1;
    exp0[0] = post(0); exp0[1] = post(2); exp0[2] = post(8); exp0[3] = post(10);
    exp1[0] = post(0); exp1[1] = post(-2); exp1[2] = post(-8); exp1[3] = post(-10);
    fork send(16, 1'b0); recv("s2", 4, 1'b0); join
    quiet("s2");
    use_s2 = 1'b0;

    // partial frame, reset, then a fresh frame with distinct values
    send(7, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 0);
    for (int i = 0; i < 16; i++) begin
      in0[i] = 100 + i; in1[i] = -i; exp0[i] = post(100 + i); exp1[i] = post(-i);
    end
    fork send(16, 1'b0); recv("midrst", 16, 1'b0); join
    quiet("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
